// File: rtl/button_event_pkg.sv
// Shared constants for the button event arbiter: command codes, arbiter
// state encodings, pending-slot indices and the fixed-priority picker.
package button_event_pkg;

    localparam logic [1:0] CMD_ENERGIA  = 2'd0;
    localparam logic [1:0] CMD_MEDICINA = 2'd1;
    localparam logic [1:0] CMD_TEST     = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    // Slot index equals the command code it produces.
    localparam int SLOT_E    = 0;
    localparam int SLOT_M    = 1;
    localparam int SLOT_T    = 2;
    localparam int NUM_SLOTS = 3;

    function automatic logic [1:0] prio_pick(input logic [NUM_SLOTS-1:0] pend);
        logic [1:0] code;
        if (pend[SLOT_T]) begin
            code = CMD_TEST;
        end else if (pend[SLOT_M]) begin
            code = CMD_MEDICINA;
        end else begin
            code = CMD_ENERGIA;
        end
        return code;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Command handshake between the button event arbiter (master) and the pet FSM (slave).
interface button_event_arbiter_if;

    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);

endinterface

// File: rtl/button_hold_detect.sv
// Registered edge detect plus hold counter. o_req fires on the rise (EMIT_RISE)
// and/or after HOLD_CYCLES of continuous hold, once or periodically (REPEAT).
module button_hold_detect #(
    parameter int unsigned HOLD_CYCLES = 32'd8,
    parameter int unsigned CNT_W       = 32'd28,
    parameter bit          EMIT_RISE   = 1'b0,
    parameter bit          REPEAT      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_req
);

    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(HOLD_CYCLES - 32'd2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 32'd1);

    logic             r_in;
    logic             r_prev;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_fire;

    assign w_rise = r_in & ~r_prev;
    // The counter steps to HOLD-1 on the same edge the request is registered.
    assign w_fire = r_armed & r_in & (r_cnt == CNT_FIRE);
    assign o_req  = (EMIT_RISE & w_rise) | w_fire;

    // Input sampling, arming and hold counting; prev resets high so a held button is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in    <= 1'b1;
            r_prev  <= 1'b1;
            r_armed <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_in   <= i_btn;
            r_prev <= r_in;
            if (w_rise) begin
                r_cnt   <= {CNT_W{1'b0}};
                r_armed <= 1'b1;
            end else if (r_armed && r_in) begin
                r_cnt <= (r_cnt == CNT_LAST) ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
                if (w_fire && !REPEAT) begin
                    r_armed <= 1'b0;
                end
            end else begin
                r_armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into prioritised one-at-a-time commands and owns test_mode.
// Optional energia auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 32'd250_000_000,
    parameter int unsigned REPEAT_CYCLES = 32'd50_000_000,
    parameter int unsigned CNT_W         = 32'd28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_test,
    input  logic                   btn_energia,
    input  logic                   btn_medicina,
    button_event_arbiter_if.master cmd_if,
    output logic                   test_mode,
    output logic                   drop
);

    logic [NUM_SLOTS-1:0] w_req;
    logic [NUM_SLOTS-1:0] w_grant;
    logic [NUM_SLOTS-1:0] w_pend_nxt;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_req_e;
    logic                 w_req_t;

    logic [NUM_SLOTS-1:0] r_pend;
    logic [0:0]           r_state;
    logic                 r_cmd_valid;
    logic [1:0]           r_cmd_code;
    logic                 r_test_mode;
    logic                 r_drop;
    logic                 r_m_in;
    logic                 r_m_prev;

    button_hold_detect #(
        .HOLD_CYCLES (LONG_CYCLES),
        .CNT_W       (CNT_W),
        .EMIT_RISE   (1'b0),
        .REPEAT      (1'b0)
    ) u_test_hold (
        .clk   (clk),
        .reset (reset),
        .i_btn (btn_test),
        .o_req (w_req_t)
    );

`ifdef BTN_AUTO_REPEAT_EN
    button_hold_detect #(
        .HOLD_CYCLES (REPEAT_CYCLES),
        .CNT_W       (CNT_W),
        .EMIT_RISE   (1'b1),
        .REPEAT      (1'b1)
    ) u_energia_repeat (
        .clk   (clk),
        .reset (reset),
        .i_btn (btn_energia),
        .o_req (w_req_e)
    );
`else
    logic r_e_in;
    logic r_e_prev;

    // Energia edge detect: one request per press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_in   <= 1'b1;
            r_e_prev <= 1'b1;
        end else begin
            r_e_in   <= btn_energia;
            r_e_prev <= r_e_in;
        end
    end

    assign w_req_e = r_e_in & ~r_e_prev;
`endif

    // Medicina edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_in   <= 1'b1;
            r_m_prev <= 1'b1;
        end else begin
            r_m_in   <= btn_medicina;
            r_m_prev <= r_m_in;
        end
    end

    // Pending-slot update: a grant and a new request in one cycle leave the slot set.
    always_comb begin
        w_req           = {NUM_SLOTS{1'b0}};
        w_req[SLOT_E]   = w_req_e;
        w_req[SLOT_M]   = r_m_in & ~r_m_prev;
        w_req[SLOT_T]   = w_req_t;
        w_accept        = r_cmd_valid & cmd_if.cmd_ready;
        w_grant         = {NUM_SLOTS{1'b0}};
        w_grant[SLOT_E] = w_accept & (r_cmd_code == CMD_ENERGIA);
        w_grant[SLOT_M] = w_accept & (r_cmd_code == CMD_MEDICINA);
        w_grant[SLOT_T] = w_accept & (r_cmd_code == CMD_TEST);
        w_pend_nxt      = w_req | (r_pend & ~w_grant);
        w_drop          = |(w_req & r_pend & ~w_grant);
    end

    // Arbiter FSM, pending slots, test_mode and drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= CMD_ENERGIA;
            r_test_mode <= 1'b0;
            r_drop      <= 1'b0;
            r_pend      <= {NUM_SLOTS{1'b0}};
        end else begin
            r_pend <= w_pend_nxt;
            r_drop <= w_drop;
            case (r_state)
                ST_IDLE: begin
                    if (|r_pend) begin
                        r_cmd_code  <= prio_pick(r_pend);
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (r_cmd_code == CMD_TEST) begin
                            r_test_mode <= ~r_test_mode;
                        end
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_if.cmd_valid = r_cmd_valid;
    assign cmd_if.cmd_code  = r_cmd_code;
    assign test_mode        = r_test_mode;
    assign drop             = r_drop;

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Takes the debounced level signals from the button debouncer (test, energia, medicina) and turns them into single, prioritised commands for the pet state machine. Each request is queued in a one-deep pending slot per button. Requests are offered one at a time on a valid/ready handshake, and the block owns the `test_mode` flag. It sits between the debouncer and the main FSM.

## Interface
- `LONG_CYCLES`, default 250_000_000: hold time for the test button (5 s at 50 MHz).
- `REPEAT_CYCLES`, default 50_000_000: auto-repeat period for energia. Used only with `BTN_AUTO_REPEAT_EN`.
- `CNT_W`, default 28: width of the hold/repeat counter. Must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `btn_test` input 1: debounced test level.
- `btn_energia` input 1: debounced energia level.
- `btn_medicina` input 1: debounced medicina level.
- `cmd_valid` output 1: a command is offered.
- `cmd_code` output 2: command code. 0 = ENERGIA, 1 = MEDICINA, 2 = TEST_TOGGLE, 3 = reserved/never driven.
- `cmd_ready` input 1: the FSM accepts the command.
- `test_mode` output 1: toggles on each accepted TEST_TOGGLE.
- `drop` output 1: one-cycle pulse when a request is lost because its slot is already pending.

## Operation
- **Press detection.** Each input is registered into `prev_x`; a rise is `btn_x & ~prev_x`.
  - `prev_x` resets to 1, so a button held through reset never produces an event.
  - The button must be released and pressed again.
- **Energia / medicina.** A rise sets `pend_e` / `pend_m`.
- **Test button (long press).**
  - A rise clears the hold counter and arms it.
  - While the button stays high, the counter increments each cycle.
  - When the counter reaches `LONG_CYCLES-1`, `pend_t` is set exactly once and the counter disarms until the next rise.
  - Releasing before that point discards the press; no drop pulse.
- **Drop rule.** A new request for slot x while `pend_x`=1 and x is not being accepted this cycle: `pend_x` stays 1 and `drop` pulses.
- **Same-cycle grant and new request.** If slot x is accepted and a new request for x arrives in the same cycle, `pend_x` stays 1 (the new request is queued). No drop.
- **Arbiter FSM.** States IDLE and OFFER.
  - **IDLE:** if any `pend` bit is set, latch the winner into `cmd_code` and go to OFFER. Fixed priority: TEST_TOGGLE > MEDICINA > ENERGIA.
  - **OFFER:** `cmd_valid`=1, and `cmd_code` stays stable until the handshake.
  - When `cmd_valid & cmd_ready`: clear that `pend` bit, toggle `test_mode` if the code is 2, and return to IDLE.
  - A higher-priority request arriving during OFFER does not pre-empt the offered command.
- **Back-to-back commands.** After a handshake there is always at least one IDLE cycle with `cmd_valid`=0.

## Timing
- **Reset values:**
  - `cmd_valid`=0, `cmd_code`=0, `test_mode`=0, `drop`=0.
  - All `pend` bits 0, counter 0, disarmed, `prev_*`=1.
  - State = IDLE.
- **Reset mid-offer.** Reset while `cmd_valid`=1 drops the command; nothing is accepted.
- **Press latency.** Input first sampled high at edge k:
  - the rise is seen in cycle k;
  - `pend` is set after edge k+1;
  - `cmd_valid`=1 after edge k+2 (FSM idle, no higher-priority request).
- **Long-press latency.** `pend_t` is set `LONG_CYCLES` cycles after the rise edge; `cmd_valid` follows one cycle later.
- **Handshake completion.** Accept at edge a: `cmd_valid`=0 and `test_mode` updated after edge a.
- **Drop timing.** `drop` is registered; it is high for the one cycle after the offending edge.

## Configuration
- **`BTN_AUTO_REPEAT_EN` defined:** while `btn_energia` stays high after its rise, a second counter issues an additional ENERGIA request every `REPEAT_CYCLES` cycles. These requests follow the normal drop rule.
- **`BTN_AUTO_REPEAT_EN` undefined:** one request per press. The repeat counter is not synthesised and `REPEAT_CYCLES` is ignored.

## Structure
- **Package `button_event_pkg`:**
  - command-code constants `CMD_ENERGIA`/`CMD_MEDICINA`/`CMD_TEST`;
  - FSM state encodings `ST_IDLE`/`ST_OFFER`;
  - slot indices.
- **Sub-module `button_hold_detect`:** edge detect plus hold counter with `HOLD_CYCLES`/`CNT_W` parameters. Instantiated for the test button, and for energia when `BTN_AUTO_REPEAT_EN` is defined.
- Arbiter, pending slots and `test_mode` live in the top module.

## Test plan
Use `LONG_CYCLES`=8, `REPEAT_CYCLES`=5, `cmd_ready` tied to 1 unless stated.
- **Single medicina press.** Medicina high at edge 10 for 3 cycles → `cmd_valid` high during cycle 12 only, `cmd_code`=1, `test_mode` stays 0.
- **Test hold vs short press.**
  - Test held for 20 cycles from edge 10 → `pend_t` set at edge 18, `cmd_code`=2 offered once, `test_mode`=1.
  - Second 5-cycle test press → no command, `test_mode` stays 1.
- **Simultaneous rises.** Energia and medicina rise on the same edge → MEDICINA offered first, then ENERGIA after one idle cycle. Codes 1 then 0, no drop.
- **Backpressure and drop.**
  - Hold `cmd_ready`=0; press energia twice → second press pulses `drop` once.
  - `cmd_code`=0 stays stable while `cmd_valid`=1.
  - Release `cmd_ready` → exactly one ENERGIA accepted.
- **Reset mid-offer.**
  - Assert `reset` while `cmd_valid`=1 with medicina still held → all outputs 0 next cycle, no command after reset.
  - Release and re-press medicina → `cmd_code`=1 offered.
- **Auto-repeat (`BTN_AUTO_REPEAT_EN`).** Hold energia for 17 cycles → four ENERGIA commands accepted (initial press + 3 repeats). Without the macro → exactly one.
